// File: rtl/register_alias_table.sv
// Register alias table for rename/dispatch. Each architectural register holds a pending bit and the ROB tag that will produce it.
// Optional macro RAT_CDB_BYPASS_EN makes the read ports also see the current-cycle CDB broadcast.
module register_alias_table #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 5,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rs1,
  input  logic [IDX_W-1:0] rs2,
  input  logic [IDX_W-1:0] rd,
  input  logic             rat_we,
  input  logic [TAG_W-1:0] rob_tag_in,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             cdb_valid,
  input  logic             flush,
  output logic             rs1_valid,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs2_valid,
  output logic [TAG_W-1:0] rs2_tag
);

  // There is no handshake: every input is sampled at every rising edge,
  // and the reads are combinational views of the registered state.
  logic [NUM_REGS-1:0]            valid_q, valid_d;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;

  // Next-state order: a flush wins, then the rename write, then the CDB clear.
  // The CDB clear is applied to the post-write view, so a write whose tag is
  // already being broadcast ends up invalid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (rat_we && (rd != '0)) begin
        valid_d[rd] = 1'b1;
        tag_d[rd]   = rob_tag_in;
      end
      if (cdb_valid) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (valid_d[i[IDX_W-1:0]] && (tag_d[i[IDX_W-1:0]] == cdb_tag)) begin
            valid_d[i[IDX_W-1:0]] = 1'b0;
          end
        end
      end
    end
    valid_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  logic             rs1_pend, rs2_pend;
  logic [TAG_W-1:0] rs1_map, rs2_map;
  logic             rs1_cdb_hit, rs2_cdb_hit;

  assign rs1_pend = valid_q[rs1];
  assign rs2_pend = valid_q[rs2];
  assign rs1_map  = tag_q[rs1];
  assign rs2_map  = tag_q[rs2];

`ifdef RAT_CDB_BYPASS_EN
  // A broadcast in this cycle completes the producer, so dispatch can treat
  // the source as ready right away.
  assign rs1_cdb_hit = cdb_valid && rs1_pend && (rs1_map == cdb_tag);
  assign rs2_cdb_hit = cdb_valid && rs2_pend && (rs2_map == cdb_tag);
`else
  assign rs1_cdb_hit = 1'b0;
  assign rs2_cdb_hit = 1'b0;
`endif

  assign rs1_valid = rs1_pend && !rs1_cdb_hit;
  assign rs2_valid = rs2_pend && !rs2_cdb_hit;
  assign rs1_tag   = rs1_valid ? rs1_map : '0;
  assign rs2_tag   = rs2_valid ? rs2_map : '0;

endmodule

// File: tb/tb_register_alias_table.sv
// Directed bench for register_alias_table. It runs a linear sequence of steps with hand-computed expectations.
module tb_register_alias_table;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       rat_we;
  logic [4:0] rob_tag_in, cdb_tag;
  logic       cdb_valid, flush;
  logic       rs1_valid, rs2_valid;
  logic [4:0] rs1_tag, rs2_tag;

  int n_assert = 0;
  int n_fail   = 0;

  register_alias_table #(.NUM_REGS(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .rat_we     (rat_we),
    .rob_tag_in (rob_tag_in),
    .cdb_tag    (cdb_tag),
    .cdb_valid  (cdb_valid),
    .flush      (flush),
    .rs1_valid  (rs1_valid),
    .rs1_tag    (rs1_tag),
    .rs2_valid  (rs2_valid),
    .rs2_tag    (rs2_tag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic write(input logic [4:0] r, input logic [4:0] t);
    rd = r; rob_tag_in = t; rat_we = 1'b1;
    step();
    rat_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rs1 = 5'd1; rs2 = 5'd2; rd = '0; rat_we = 1'b0;
    rob_tag_in = '0; cdb_tag = '0; cdb_valid = 1'b0; flush = 1'b0;
    #12;
    chk("reset_rs1_valid_low", {7'd0, rs1_valid}, 8'd0);
    rst_n = 1'b1;
    step();
    chk("reset_rs1_valid", {7'd0, rs1_valid}, 8'd0);
    chk("reset_rs1_tag",   {3'd0, rs1_tag},   8'd0);
    chk("reset_rs2_valid", {7'd0, rs2_valid}, 8'd0);
    chk("reset_rs2_tag",   {3'd0, rs2_tag},   8'd0);

    // Rename x1 -> 5; no write-to-read bypass before the edge.
    rd = 5'd1; rob_tag_in = 5'd5; rat_we = 1'b1; rs1 = 5'd1;
    #1;
    chk("prewrite_rs1_valid", {7'd0, rs1_valid}, 8'd0);
    step();
    chk("rename_rs1_valid", {7'd0, rs1_valid}, 8'd1);
    chk("rename_rs1_tag",   {3'd0, rs1_tag},   8'd5);

    // Write of tag 5 with simultaneous CDB 5 ends invalid.
    cdb_tag = 5'd5; cdb_valid = 1'b1;
    step();
    chk("cdb_same_tag_valid", {7'd0, rs1_valid}, 8'd0);
    chk("cdb_same_tag_tag",   {3'd0, rs1_tag},   8'd0);
    rat_we = 1'b0;
    step();
    chk("cdb_nowrite_valid", {7'd0, rs1_valid}, 8'd0);
    cdb_valid = 1'b0;

    // x3 and x4 both map to 9; one broadcast clears both.
    write(5'd3, 5'd9);
    write(5'd4, 5'd9);
    rs1 = 5'd3; rs2 = 5'd4;
    #1;
    chk("map_x3_tag", {3'd0, rs1_tag}, 8'd9);
    chk("map_x4_tag", {3'd0, rs2_tag}, 8'd9);
    cdb_tag = 5'd9; cdb_valid = 1'b1;
    step();
    cdb_valid = 1'b0;
    chk("multi_clr_x3", {7'd0, rs1_valid}, 8'd0);
    chk("multi_clr_x4", {7'd0, rs2_valid}, 8'd0);

    // x0 writes ignored.
    write(5'd0, 5'd10);
    rs1 = 5'd0;
    #1;
    chk("x0_valid", {7'd0, rs1_valid}, 8'd0);
    chk("x0_tag",   {3'd0, rs1_tag},   8'd0);

    // Flush clears everything, even with a concurrent write.
    write(5'd5, 5'd8);
    write(5'd2, 5'd7);
    rs2 = 5'd2;
    #1;
    chk("pre_flush_rs2_valid", {7'd0, rs2_valid}, 8'd1);
    chk("pre_flush_rs2_tag",   {3'd0, rs2_tag},   8'd7);
    flush = 1'b1; rd = 5'd2; rob_tag_in = 5'd7; rat_we = 1'b1;
    step();
    flush = 1'b0; rat_we = 1'b0;
    chk("flush_rs2_valid", {7'd0, rs2_valid}, 8'd0);
    chk("flush_rs2_tag",   {3'd0, rs2_tag},   8'd0);
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0];
      #1;
      chk($sformatf("flush_all_x%0d", i), {7'd0, rs1_valid}, 8'd0);
    end

    // Write with a different tag survives a CDB broadcast.
    rd = 5'd6; rob_tag_in = 5'd3; rat_we = 1'b1; cdb_tag = 5'd4; cdb_valid = 1'b1;
    step();
    rat_we = 1'b0; cdb_valid = 1'b0; rs1 = 5'd6;
    #1;
    chk("write_vs_cdb_valid", {7'd0, rs1_valid}, 8'd1);
    chk("write_vs_cdb_tag",   {3'd0, rs1_tag},   8'd3);
    cdb_tag = 5'd3; cdb_valid = 1'b1;
    #1;
`ifdef RAT_CDB_BYPASS_EN
    chk("bypass_rs1_valid", {7'd0, rs1_valid}, 8'd0);
    chk("bypass_rs1_tag",   {3'd0, rs1_tag},   8'd0);
`else
    chk("nobypass_rs1_valid", {7'd0, rs1_valid}, 8'd1);
    chk("nobypass_rs1_tag",   {3'd0, rs1_tag},   8'd3);
`endif
    step();
    cdb_valid = 1'b0;
    chk("cdb_after_edge_x6", {7'd0, rs1_valid}, 8'd0);

    // CDB clears only matching tags.
    write(5'd8, 5'd12);
    write(5'd9, 5'd13);
    cdb_tag = 5'd12; cdb_valid = 1'b1;
    step();
    cdb_valid = 1'b0; rs1 = 5'd8; rs2 = 5'd9;
    #1;
    chk("match_only_x8", {7'd0, rs1_valid}, 8'd0);
    chk("match_only_x9_valid", {7'd0, rs2_valid}, 8'd1);
    chk("match_only_x9_tag",   {3'd0, rs2_tag},   8'd13);

    // Asynchronous reset mid-operation.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_x9", {7'd0, rs2_valid}, 8'd0);
    chk("async_reset_x9_tag", {3'd0, rs2_tag}, 8'd0);
    rst_n = 1'b1;
    step();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_alias_table.md
Name: register_alias_table

Overview:
Register Alias Table for the Tomasulo rename/dispatch stage. Tracks, for each of the 32 architectural integer registers, whether a value is pending from an in-flight ROB entry and which ROB tag will produce it. Dispatch reads two source mappings and writes one destination mapping per cycle. Entries are cleared by CDB broadcasts and by a pipeline flush.

Parameters:
NUM_REGS, 32, number of architectural registers (x0..x31); the index width is log2(NUM_REGS) = 5.
TAG_W, 5, ROB tag width (32 ROB entries).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous reset, active-low.
rs1  input  5  source register 1 index (read port A).
rs2  input  5  source register 2 index (read port B).
rd  input  5  destination register index for the rename write.
rat_we  input  1  rename write enable (dispatch).
rob_tag_in  input  TAG_W  ROB tag allocated to rd.
cdb_tag  input  TAG_W  ROB tag being broadcast on the CDB.
cdb_valid  input  1  CDB broadcast valid.
flush  input  1  mispredict/exception flush; clears all mappings.
rs1_valid  output  1  1 = rs1 is renamed (value pending in the ROB).
rs1_tag  output  TAG_W  ROB tag producing rs1.
rs2_valid  output  1  same as rs1_valid, for rs2.
rs2_tag  output  TAG_W  same as rs1_tag, for rs2.

Behaviour:
- State: per register, one valid bit and one TAG_W tag.
- Reset (rst_n low, asynchronous): all valid bits = 0 and all tags = 0. Outputs are then valid = 0 and tag = 0 on both ports.
- Reads are combinational from registered state, with zero latency.
  - rsX_valid = valid[rsX].
  - rsX_tag = tag[rsX] when valid, otherwise 0.
  - A write in the current cycle is not visible until after the clock edge; there is no write-to-read bypass.
- x0 is hardwired unrenamed. Writes with rd == 0 are ignored. Reads of x0 always return valid = 0, tag = 0.
- Next-state priority at the rising edge, highest first:
  1. flush = 1: every valid bit cleared. Simultaneous rat_we and CDB are ignored; tags may keep their stale values.
  2. Rename write: if rat_we = 1 and rd != 0, then valid[rd] = 1 and tag[rd] = rob_tag_in.
  3. CDB clear, applied to the result of step 2: if cdb_valid = 1, every entry with valid = 1 and tag == cdb_tag gets valid = 0.
- Consequence of step 3: if the same cycle writes rob_tag_in == cdb_tag, that entry ends invalid, because the value is already complete.
- A write with a different tag survives a simultaneous CDB broadcast.
- The CDB clears all matching entries, not only the first one found.
- rd == rs1 or rd == rs2 in the same cycle: reads return the pre-write mapping.
- No handshake; all inputs are sampled every edge. Reset mid-operation discards all mappings immediately.

Optional Feature:
Macro RAT_CDB_BYPASS_EN.
- Defined: read ports also see the current-cycle CDB. If cdb_valid = 1 and valid[rsX] = 1 and tag[rsX] == cdb_tag, then rsX_valid = 0 and rsX_tag = 0 combinationally. This lets dispatch avoid waiting on a tag broadcast in the same cycle. Registered state updates are unchanged.
- Not defined: reads reflect registered state only, as described in Behaviour.

Test Plan:
- Reset: rst_n low then high, rs1 = 1, rs2 = 2 -> rs1_valid = 0, rs2_valid = 0, both tags 0.
- Rename: rd = 1, rob_tag_in = 5, rat_we = 1, one edge, rs1 = 1 -> rs1_valid = 1, rs1_tag = 5.
- CDB clear: cdb_tag = 5, cdb_valid = 1 while rd = 1, rob_tag_in = 5, rat_we = 1 remain asserted, one edge -> rs1_valid = 0. Repeat with no write -> still 0. Also map x3 and x4 both to tag 9, broadcast 9 -> both cleared.
- x0: rd = 0, rob_tag_in = 10, rat_we = 1, one edge, rs1 = 0 -> rs1_valid = 0, rs1_tag = 0.
- Flush: rd = 2, rob_tag_in = 7, rat_we = 1, one edge -> rs2_valid = 1, rs2_tag = 7. Then flush = 1 with rat_we still 1, one edge -> rs2_valid = 0, and all registers read invalid.
- Write vs CDB: rd = 6, tag 3 written while cdb broadcasts tag 4 -> x6 valid, tag 3. With RAT_CDB_BYPASS_EN defined, x6 mapped to 3 and cdb_tag = 3 valid -> rs1_valid = 0 in the same cycle, before the edge.
